multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle main control FSM for the MIPS core; replaces the single-cycle opcode decoder.
//  Sequences each instruction through fetch/decode/execute/memory/writeback states.
//  Drives datapath enables, muxes and alu_op. Stalls on a ready handshake from unified memory.
//  Flags unsupported opcodes and counts retired instructions.
// PARAMETERS
//  OPCODE_W  6   opcode field width
//  ALUOP_W   2   alu_op width (00 add, 01 sub, 10 use funct)
//  CNT_W     32  retired-instruction counter width
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         asynchronous active-low reset
//  opcode         in   OPCODE_W  IR[31:26]; sampled only in DECODE
//  mem_ready      in   1         memory has completed the current read/write this cycle
//  pc_write       out  1         unconditional PC load
//  pc_write_cond  out  1         PC load gated by the ALU zero flag
//  branch_ne      out  1         1: pc_write_cond uses !zero (BNE); 0: uses zero
//  pc_source      out  2         00 ALU result, 01 ALUOut, 10 jump target
//  i_or_d         out  1         memory address: 0 PC, 1 ALUOut
//  mem_read       out  1         memory read request
//  mem_write      out  1         memory write request
//  ir_write       out  1         load instruction register
//  mem_to_reg     out  1         writeback source: 1 MDR, 0 ALUOut
//  reg_dst        out  1         dest register: 1 rd, 0 rt
//  reg_write      out  1         register-file write enable
//  alu_src_a      out  1         0 PC, 1 rs
//  alu_src_b      out  2         00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op         out  ALUOP_W   ALU control class
//  illegal_op     out  1         one-cycle pulse: unsupported opcode decoded
//  instr_retired  out  1         one-cycle pulse on final state of each instruction
//  retired_count  out  CNT_W     running count of retired instructions
// BEHAVIOUR
//  Reset: state=FETCH, retired_count=0. Outputs are decoded from the state, Moore-style.
//   All outputs not listed per state are 0; alu_op=00 unless stated.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01.
//   Hold while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, pc_source=00, go to DECODE.
//   ir_write and pc_write are asserted only in the mem_ready cycle.
//  DECODE: alu_src_a=0, alu_src_b=11 (branch target into ALUOut). Next state by opcode:
//   0x00 RTYPE->EXEC_R; 0x08 ADDI->EXEC_I; 0x23 LW, 0x2B SW->MEM_ADDR; 0x04 BEQ, 0x05 BNE->BRANCH;
//   0x02 J->JUMP; any other opcode->FETCH with illegal_op=1 (not counted as retired).
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R.
//  WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; retire -> FETCH.
//  EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB_I.
//  WB_I: reg_write=1, reg_dst=0, mem_to_reg=0; retire -> FETCH.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD (LW) or MEM_WR (SW).
//   The opcode is latched in DECODE; later transitions use the latched copy, never the live port.
//  MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then -> WB_MEM.
//  WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; retire -> FETCH.
//  MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready=1; retire in that cycle -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
//   branch_ne=1 for BNE, 0 for BEQ; retire -> FETCH.
//  JUMP: pc_write=1, pc_source=10; retire -> FETCH.
//  Latency in cycles, with zero memory wait: R/ADDI 4, BEQ/BNE/J 3, SW 4, LW 5.
//   Each memory wait cycle adds one cycle.
//  Retire: instr_retired=1 for exactly one cycle, and retired_count increments in that cycle.
//   The counter wraps modulo 2^CNT_W.
//  Reset mid-instruction: return immediately to FETCH with every strobe low.
//   No partial reg_write or mem_write may follow reset.
//  mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
//  Unreachable state encodings recover to FETCH on the next clock.
// STRUCTURE
//  Shared package mips_pkg: opcode constants (RTYPE, ADDI, LW, SW, BEQ, BNE, J).
//   Also the alu_op encodings, the alu_src_b and pc_source mux encodings, and the state enum.
//  One sub-module, retire_counter: CNT_W-bit counter with enable and async clear. Rest is a flat FSM.
// TESTING
//  ADDI (0x08), mem_ready tied 1 -> states F,D,EXEC_I,WB_I.
//   Check: reg_write=1, reg_dst=0 in cycle 4; instr_retired pulse; retired_count 0->1.
//  LW (0x23), mem_ready=0 for 2 cycles in MEM_RD -> mem_read and i_or_d held.
//   Check: mem_to_reg=1 and reg_write=1 in cycle 7; total 7 cycles.
//  BNE (0x05) -> BRANCH cycle shows pc_write_cond=1, branch_ne=1, alu_op=01, pc_source=01.
//   BEQ (0x04) gives the same with branch_ne=0.
//  J (0x02) -> pc_write=1, pc_source=10 in cycle 3. Opcode 0x3F -> illegal_op pulse in DECODE.
//   Check: back in FETCH next cycle; retired_count unchanged.
//  SW in MEM_WR with mem_write=1: drop rst_n -> all strobes 0 asynchronously, state FETCH, count 0.
//  opcode changed to 0x2B after DECODE of LW -> still takes MEM_RD path (latched opcode).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, mux/ALU encodings and the
// multi-cycle controller state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
    } stateT;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller-to-datapath bundle: instruction/memory status in, control strobes
// and mux selects out.
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
) ();
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic                illegal_op;
    logic                instr_retired;
    logic [CNT_W-1:0]    retired_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, illegal_op, instr_retired, retired_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, illegal_op, instr_retired, retired_count
    );
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (en) count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback, stalls on mem_ready, flags illegal opcodes, counts retirements.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    stateT               stateQ, stateD;
    logic [OPCODE_W-1:0] opcodeQ;
    logic                retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= S_FETCH;
            opcodeQ <= '0;
        end else begin
            stateQ <= stateD;
            if (stateQ == S_DECODE) opcodeQ <= bus.opcode;
        end
    end

    // NOTE: every output and stateD gets a default first so no path through
    // the case below can infer a latch.
    always_comb begin
        stateD            = stateQ;
        retire            = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_source     = PCSRC_ALU;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.alu_op        = ALUOP_W'(ALU_ADD);
        bus.illegal_op    = 1'b0;

        // Reset forces every strobe low immediately, not just at the next edge.
        if (rst_n) begin
            unique case (stateQ)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        stateD       = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = SRCB_IMM_SH2;
                    if      (bus.opcode == OPCODE_W'(OP_RTYPE)) stateD = S_EXEC_R;
                    else if (bus.opcode == OPCODE_W'(OP_ADDI))  stateD = S_EXEC_I;
                    else if (bus.opcode == OPCODE_W'(OP_LW) ||
                             bus.opcode == OPCODE_W'(OP_SW))    stateD = S_MEM_ADDR;
                    else if (bus.opcode == OPCODE_W'(OP_BEQ) ||
                             bus.opcode == OPCODE_W'(OP_BNE))   stateD = S_BRANCH;
                    else if (bus.opcode == OPCODE_W'(OP_J))     stateD = S_JUMP;
                    else begin
                        bus.illegal_op = 1'b1;
                        stateD         = S_FETCH;
                    end
                end
                S_EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALUOP_W'(ALU_FUNCT);
                    stateD        = S_WB_R;
                end
                S_WB_R: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                    retire        = 1'b1;
                    stateD        = S_FETCH;
                end
                S_EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    stateD        = S_WB_I;
                end
                S_WB_I: begin
                    bus.reg_write = 1'b1;
                    retire        = 1'b1;
                    stateD        = S_FETCH;
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    stateD = (opcodeQ == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                    if (bus.mem_ready) stateD = S_WB_MEM;
                end
                S_WB_MEM: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    retire         = 1'b1;
                    stateD         = S_FETCH;
                end
                S_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                    if (bus.mem_ready) begin
                        retire = 1'b1;
                        stateD = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALUOP_W'(ALU_SUB);
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = PCSRC_ALUOUT;
                    bus.branch_ne     = (opcodeQ == OPCODE_W'(OP_BNE));
                    retire            = 1'b1;
                    stateD            = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCSRC_JUMP;
                    retire        = 1'b1;
                    stateD        = S_FETCH;
                end
                default: stateD = S_FETCH;
            endcase
        end
    end

    assign bus.instr_retired = retire;

    retire_counter #(.CNT_W(CNT_W)) uRetireCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire),
        .count (bus.retired_count)
    );
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: compares the full control word and
// retired count against hand-derived per-state expectations every cycle.
module tb_multicycle_control;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(32)) bus ();

    multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Control word: pcWrite pcWriteCond branchNe pcSource[2] iOrD memRead memWrite
    //   irWrite memToReg regDst regWrite aluSrcA aluSrcB[2] aluOp[2] illegalOp retired
    logic [18:0] actCtl;
    assign actCtl = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_source,
                     bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                     bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.illegal_op, bus.instr_retired};

    localparam logic [18:0] E_IDLE      = 19'b0_0_0_00_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [18:0] E_FETCH_W   = 19'b0_0_0_00_0_1_0_0_0_0_0_0_01_00_0_0;
    localparam logic [18:0] E_FETCH_R   = 19'b1_0_0_00_0_1_0_1_0_0_0_0_01_00_0_0;
    localparam logic [18:0] E_DECODE    = 19'b0_0_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
    localparam logic [18:0] E_DEC_ILL   = 19'b0_0_0_00_0_0_0_0_0_0_0_0_11_00_1_0;
    localparam logic [18:0] E_EXEC_R    = 19'b0_0_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam logic [18:0] E_WB_R      = 19'b0_0_0_00_0_0_0_0_0_1_1_0_00_00_0_1;
    localparam logic [18:0] E_EXEC_I    = 19'b0_0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [18:0] E_WB_I      = 19'b0_0_0_00_0_0_0_0_0_0_1_0_00_00_0_1;
    localparam logic [18:0] E_MEM_ADDR  = 19'b0_0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [18:0] E_MEM_RD    = 19'b0_0_0_00_1_1_0_0_0_0_0_0_00_00_0_0;
    localparam logic [18:0] E_WB_MEM    = 19'b0_0_0_00_0_0_0_0_1_0_1_0_00_00_0_1;
    localparam logic [18:0] E_MEM_WR_W  = 19'b0_0_0_00_1_0_1_0_0_0_0_0_00_00_0_0;
    localparam logic [18:0] E_MEM_WR_R  = 19'b0_0_0_00_1_0_1_0_0_0_0_0_00_00_0_1;
    localparam logic [18:0] E_BR_BNE    = 19'b0_1_1_01_0_0_0_0_0_0_0_1_00_01_0_1;
    localparam logic [18:0] E_BR_BEQ    = 19'b0_1_0_01_0_0_0_0_0_0_0_1_00_01_0_1;
    localparam logic [18:0] E_JUMP      = 19'b1_0_0_10_0_0_0_0_0_0_0_0_00_00_0_1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkCycle(input string tag, input logic [18:0] expCtl, input int expCnt);
        check({tag, "/ctl"}, {13'b0, actCtl}, {13'b0, expCtl});
        check({tag, "/cnt"}, bus.retired_count, 32'(expCnt));
    endtask

    // Starts a new cycle: inputs change 1 time unit after the edge, checks at +3.
    task automatic step(input logic [5:0] op, input logic rdy);
        @(posedge clk);
        #1;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #2;
    endtask

    initial begin
        bus.opcode    = OP_RTYPE;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        #2 checkCycle("reset", E_IDLE, 0);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;

        // ADDI, no wait: F, D, EXEC_I, WB_I
        step(OP_ADDI, 1'b1); checkCycle("addi_f",  E_FETCH_R, 0);
        step(OP_ADDI, 1'b1); checkCycle("addi_d",  E_DECODE,  0);
        step(OP_ADDI, 1'b1); checkCycle("addi_ex", E_EXEC_I,  0);
        step(OP_ADDI, 1'b1); checkCycle("addi_wb", E_WB_I,    0);

        // LW with two wait cycles in MEM_RD: 7 cycles total
        step(OP_LW, 1'b1); checkCycle("lw_f",    E_FETCH_R,  1);
        step(OP_LW, 1'b1); checkCycle("lw_d",    E_DECODE,   1);
        step(OP_LW, 1'b1); checkCycle("lw_addr", E_MEM_ADDR, 1);
        step(OP_LW, 1'b0); checkCycle("lw_w1",   E_MEM_RD,   1);
        step(OP_LW, 1'b0); checkCycle("lw_w2",   E_MEM_RD,   1);
        step(OP_LW, 1'b1); checkCycle("lw_rd",   E_MEM_RD,   1);
        step(OP_LW, 1'b1); checkCycle("lw_wb",   E_WB_MEM,   1);

        // BNE with one fetch wait
        step(OP_BNE, 1'b0); checkCycle("bne_fw", E_FETCH_W, 2);
        step(OP_BNE, 1'b1); checkCycle("bne_f",  E_FETCH_R, 2);
        step(OP_BNE, 1'b1); checkCycle("bne_d",  E_DECODE,  2);
        step(OP_BNE, 1'b1); checkCycle("bne_br", E_BR_BNE,  2);

        step(OP_BEQ, 1'b1); checkCycle("beq_f",  E_FETCH_R, 3);
        step(OP_BEQ, 1'b1); checkCycle("beq_d",  E_DECODE,  3);
        step(OP_BEQ, 1'b1); checkCycle("beq_br", E_BR_BEQ,  3);

        step(OP_J, 1'b1); checkCycle("j_f", E_FETCH_R, 4);
        step(OP_J, 1'b1); checkCycle("j_d", E_DECODE,  4);
        step(OP_J, 1'b1); checkCycle("j_j", E_JUMP,    4);

        // Illegal opcode: pulse in DECODE, back to FETCH, not counted
        step(6'h3F, 1'b1); checkCycle("ill_f", E_FETCH_R, 5);
        step(6'h3F, 1'b1); checkCycle("ill_d", E_DEC_ILL, 5);

        // LW whose opcode changes to SW after DECODE must still read
        step(OP_LW, 1'b1); checkCycle("lat_f",    E_FETCH_R,  5);
        step(OP_LW, 1'b1); checkCycle("lat_d",    E_DECODE,   5);
        step(OP_SW, 1'b1); checkCycle("lat_addr", E_MEM_ADDR, 5);
        step(OP_SW, 1'b1); checkCycle("lat_rd",   E_MEM_RD,   5);
        step(OP_SW, 1'b1); checkCycle("lat_wb",   E_WB_MEM,   5);

        step(OP_RTYPE, 1'b1); checkCycle("r_f",  E_FETCH_R, 6);
        step(OP_RTYPE, 1'b1); checkCycle("r_d",  E_DECODE,  6);
        step(OP_RTYPE, 1'b1); checkCycle("r_ex", E_EXEC_R,  6);
        step(OP_RTYPE, 1'b1); checkCycle("r_wb", E_WB_R,    6);

        step(OP_SW, 1'b1); checkCycle("sw_f",    E_FETCH_R,  7);
        step(OP_SW, 1'b1); checkCycle("sw_d",    E_DECODE,   7);
        step(OP_SW, 1'b1); checkCycle("sw_addr", E_MEM_ADDR, 7);
        step(OP_SW, 1'b1); checkCycle("sw_wr",   E_MEM_WR_R, 7);

        // SW stalled in MEM_WR, then asynchronous reset mid-cycle
        step(OP_SW, 1'b1); checkCycle("swr_f",    E_FETCH_R,  8);
        step(OP_SW, 1'b1); checkCycle("swr_d",    E_DECODE,   8);
        step(OP_SW, 1'b1); checkCycle("swr_addr", E_MEM_ADDR, 8);
        step(OP_SW, 1'b0); checkCycle("swr_wait", E_MEM_WR_W, 8);
        #1 rst_n = 1'b0;
        #1 checkCycle("swr_rst", E_IDLE, 0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #2 checkCycle("post_rst", E_FETCH_W, 0);
        step(OP_ADDI, 1'b1); checkCycle("post_f", E_FETCH_R, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
